mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Registered, round-robin arbiter with a per-transaction watchdog that terminates hung accesses with an error response.
- Sits between the core datapath (fetch/LSU ports) and the memory model or bus bridge; one outstanding memory transaction at a time.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, load/store port and memory port.
// master is the arbiter's view; slave is the view of the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ack;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            d_err;

    logic            m_req;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  m_rdata, m_ack,
        output i_rdata, i_ack, i_err,
        output d_rdata, d_ack, d_err,
        output m_req, m_we, m_be, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output m_rdata, m_ack,
        input  i_rdata, i_ack, i_err,
        input  d_rdata, d_ack, d_err,
        input  m_req, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch (I) and load/store (D),
// one transaction at a time, with a watchdog that ends a hung access with an error pulse.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_reg;
    logic          last_grant_reg;   // 1 = D was granted last
    logic [CW-1:0] wd_cnt_reg;
    logic          m_req_reg;
    logic          m_we_reg;
    logic [BW-1:0] m_be_reg;
    logic [AW-1:0] m_addr_reg;
    logic [DW-1:0] m_wdata_reg;

    logic grant_i;
    logic grant_d;
    logic expire;
    logic i_done;
    logic d_done;

    // I wins when alone or when D was served last; D takes whatever I does not
    assign grant_i = bus.i_req && (!bus.d_req || last_grant_reg);
    assign grant_d = bus.d_req && !grant_i;

    // An ack in the expiry cycle takes priority over the error
    assign expire = (state_reg != IDLE) && !bus.m_ack && (wd_cnt_reg == WD_LAST);
    assign i_done = bus.m_ack && (state_reg == BUSY_I);
    assign d_done = bus.m_ack && (state_reg == BUSY_D);

    assign bus.i_ack   = i_done;
    assign bus.d_ack   = d_done;
    assign bus.i_err   = expire && (state_reg == BUSY_I);
    assign bus.d_err   = expire && (state_reg == BUSY_D);
    assign bus.m_req   = m_req_reg;
    assign bus.m_we    = m_we_reg;
    assign bus.m_be    = m_be_reg;
    assign bus.m_addr  = m_addr_reg;
    assign bus.m_wdata = m_wdata_reg;

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_lane
            assign bus.i_rdata[gi*8 +: 8] = i_done ? bus.m_rdata[gi*8 +: 8] : 8'h00;
            assign bus.d_rdata[gi*8 +: 8] = d_done ? bus.m_rdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            wd_cnt_reg     <= '0;
            m_req_reg      <= 1'b0;
            m_we_reg       <= 1'b0;
            m_be_reg       <= '0;
            m_addr_reg     <= '0;
            m_wdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        state_reg      <= BUSY_I;
                        last_grant_reg <= 1'b0;
                        wd_cnt_reg     <= '0;
                        m_req_reg      <= 1'b1;
                        m_we_reg       <= 1'b0;
                        m_be_reg       <= '1;
                        m_addr_reg     <= bus.i_addr;
                        m_wdata_reg    <= '0;
                    end else if (grant_d) begin
                        state_reg      <= BUSY_D;
                        last_grant_reg <= 1'b1;
                        wd_cnt_reg     <= '0;
                        m_req_reg      <= 1'b1;
                        m_we_reg       <= bus.d_we;
                        m_be_reg       <= bus.d_be;
                        m_addr_reg     <= bus.d_addr;
                        m_wdata_reg    <= bus.d_wdata;
                    end
                end
                default: begin
                    // Payload stays frozen until the next grant
                    if (bus.m_ack || expire) begin
                        state_reg <= IDLE;
                        m_req_reg <= 1'b0;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions plus
// hand-written tie, watchdog, idle-ack and mid-access reset sequences.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;      // m_req cycle in which memory acks; 0 = never
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    txn_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   busy_cnt = 0;
    bit   just_done = 0;
    bit   hold = 0;
    bit   force_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic raise(input txn_t t);
        if (t.is_d) begin
            bus.d_req = 1'b1; bus.d_we = t.we; bus.d_be = t.be;
            bus.d_addr = t.addr; bus.d_wdata = t.wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = t.addr;
        end
        exp_q.push_back(t);
    endtask

    // One clock: memory model responds from the scoreboard head, then all outputs are checked.
    task automatic step();
        txn_t h;
        bit   exp_mreq, ackd, errd;
        h = '0; ackd = 0; errd = 0;
        @(negedge clk);
        exp_mreq  = (exp_q.size() > 0) && !just_done;
        just_done = 0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom() | 32'h1;
        check("m_req", {31'b0, bus.m_req}, {31'b0, exp_mreq});
        if (exp_mreq) begin
            h = exp_q[0];
            busy_cnt++;
            check("m_addr", bus.m_addr, h.addr);
            check("m_we", {31'b0, bus.m_we}, {31'b0, h.we});
            check("m_be", {28'b0, bus.m_be}, {28'b0, h.be});
            check("m_wdata", bus.m_wdata, h.wdata);
            if (h.lat == busy_cnt) begin
                bus.m_ack = 1'b1; bus.m_rdata = h.rdata; ackd = 1;
            end else if (busy_cnt == TIMEOUT) begin
                errd = 1;
            end
        end else if (force_ack) begin
            bus.m_ack = 1'b1;
        end
        #1;
        check("i_ack", {31'b0, bus.i_ack}, {31'b0, ackd && !h.is_d});
        check("d_ack", {31'b0, bus.d_ack}, {31'b0, ackd && h.is_d});
        check("i_err", {31'b0, bus.i_err}, {31'b0, errd && !h.is_d});
        check("d_err", {31'b0, bus.d_err}, {31'b0, errd && h.is_d});
        check("i_rdata", bus.i_rdata, (ackd && !h.is_d) ? h.rdata : 32'h0);
        check("d_rdata", bus.d_rdata, (ackd && h.is_d) ? h.rdata : 32'h0);
        if (ackd || errd) begin
            $display("txn %s addr=%h we=%0d %s after %0d cycles", h.is_d ? "D" : "I",
                     h.addr, h.we, ackd ? "ack" : "err", busy_cnt);
            void'(exp_q.pop_front());
            busy_cnt  = 0;
            just_done = 1;
            if (!hold) begin
                if (h.is_d) bus.d_req = 1'b0;
                else bus.i_req = 1'b0;
            end
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            exp_q.delete();
            busy_cnt = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        txn_t vec [5];
        txn_t t;
        int   n;

        vec[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0050_0093, 1};
        vec[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hDEAD_BEEF, 32'h1111_2222, 3};
        vec[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'hCAFE_0001, 32'h1234_5678, 2};
        vec[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h8765_4321, TIMEOUT};
        vec[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0};

        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack = 0; bus.m_rdata = '0;

        #1;
        check("rst_m_req", {31'b0, bus.m_req}, 32'h0);
        check("rst_m_we", {31'b0, bus.m_we}, 32'h0);
        check("rst_m_be", {28'b0, bus.m_be}, 32'h0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Isolated transactions, including ack-on-expiry and a timed-out store
        foreach (vec[k]) begin
            hold = 0;
            if (!vec[k].is_d) begin
                bus.d_we = 1'b1; bus.d_be = 4'h5; bus.d_wdata = $urandom();
            end
            raise(vec[k]);
            drain(n);
            check("latency", n, (vec[k].lat == 0) ? TIMEOUT : vec[k].lat);
            step();
        end

        // m_ack with nothing outstanding must produce nothing
        force_ack = 1;
        step();
        step();
        force_ack = 0;

        // Continuous tie: I, D, I, D at two cycles each
        hold = 1;
        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hA1A1_A1A1, 1}; raise(t);
        t = '{1'b1, 1'b0, 4'hC, 32'h0000_0300, 32'h5555_0000, 32'hB2B2_B2B2, 1}; raise(t);
        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hC3C3_C3C3, 1}; raise(t);
        t = '{1'b1, 1'b0, 4'hC, 32'h0000_0300, 32'h5555_0000, 32'hD4D4_D4D4, 1}; raise(t);
        drain(n);
        bus.i_req = 0; bus.d_req = 0; hold = 0;
        check("tie_cycles", n, 7);
        step();

        // Hung load times out, then a fetch that arrived meanwhile is served
        t = '{1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h0, 0}; raise(t);
        step();
        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h6060_6060, 1}; raise(t);
        drain(n);
        check("wd_cycles", n + 1, TIMEOUT + 2);
        step();

        // Reset in the middle of a fetch
        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 32'hAAAA_5555, 5}; raise(t);
        step();
        step();
        #2;
        bus.m_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_req", {31'b0, bus.m_req}, 32'h0);
        check("mid_rst_m_addr", bus.m_addr, 32'h0);
        check("mid_rst_m_be", {28'b0, bus.m_be}, 32'h0);
        check("mid_rst_i_ack", {31'b0, bus.i_ack}, 32'h0);
        check("mid_rst_i_rdata", bus.i_rdata, 32'h0);
        exp_q.delete();
        busy_cnt = 0; just_done = 0;
        bus.i_req = 0; bus.m_ack = 0;
        @(negedge clk);
        rst_n = 1'b1;
        t = '{1'b0, 1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h0808_0808, 2}; raise(t);
        t = '{1'b1, 1'b0, 4'h1, 32'h0000_0900, 32'h7777_7777, 32'h0909_0909, 1}; raise(t);
        drain(n);
        check("post_rst_cycles", n, 4);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
